// File: rtl/spi_responder_if.sv
// Bus bundle between an SPI mode-3 responder and its surroundings: serial
// pins from the master plus the parallel word and status side.
interface spi_responder_if #(
    parameter int SIZE = 40
);
    logic            sclk_in;
    logic            cs_n_in;
    logic            serial_in;
    logic            serial_out;
    logic            serial_oe_out;
    logic [SIZE-1:0] tx_data_in;
    logic [SIZE-1:0] rx_data_out;
    logic            rx_valid_out;
    logic            frame_error_out;
    logic            busy_out;

    modport master (
        output sclk_in, cs_n_in, serial_in, tx_data_in,
        input  serial_out, serial_oe_out, rx_data_out, rx_valid_out,
               frame_error_out, busy_out
    );

    modport slave (
        input  sclk_in, cs_n_in, serial_in, tx_data_in,
        output serial_out, serial_oe_out, rx_data_out, rx_valid_out,
               frame_error_out, busy_out
    );
endinterface

// File: rtl/spi_responder.sv
// Oversampled SPI mode-3 (CPOL=1, CPHA=1) responder, MSB first. Serial pins are
// synchronized into clk_in; shifting happens on detected sclk edges.
module spi_responder #(
    parameter int SIZE        = 40,
    parameter int SYNC_STAGES = 2
) (
    input  logic          clk_in,
    input  logic          reset_in,
    spi_responder_if.slave bus
);
    localparam int CNT_W = $clog2(SIZE + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(SIZE);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(SIZE + 1);

    typedef enum logic [1:0] {IDLE, ACTIVE, END} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] cs_n_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sclk_prev;
    logic                   sclk_s;
    logic                   cs_n_s;
    logic                   mosi_s;
    logic                   sclk_rise;
    logic                   sclk_fall;
    logic [CNT_W-1:0]       bit_cnt;
    logic [SIZE-2:0]        tx_shift;
    logic [SIZE-1:0]        rx_shift;

    // Identical chains on all three pins keep mosi aligned with the detected edge.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            sclk_sync <= {SYNC_STAGES{1'b1}};
            cs_n_sync <= {SYNC_STAGES{1'b1}};
            mosi_sync <= '0;
            sclk_prev <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.sclk_in};
            cs_n_sync <= {cs_n_sync[SYNC_STAGES-2:0], bus.cs_n_in};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.serial_in};
            sclk_prev <= sclk_s;
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_n_s    = cs_n_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev;
    assign sclk_fall = ~sclk_s & sclk_prev;

    // tx_shift holds only the bits still to come; the current bit sits on serial_out.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state               <= IDLE;
            bit_cnt             <= '0;
            tx_shift            <= '0;
            rx_shift            <= '0;
            bus.serial_out      <= 1'b0;
            bus.serial_oe_out   <= 1'b0;
            bus.rx_data_out     <= '0;
            bus.rx_valid_out    <= 1'b0;
            bus.frame_error_out <= 1'b0;
            bus.busy_out        <= 1'b0;
        end else begin
            bus.rx_valid_out    <= 1'b0;
            bus.frame_error_out <= 1'b0;
            case (state)
                IDLE: begin
                    bus.serial_out <= bus.tx_data_in[SIZE-1];
                    if (!cs_n_s) begin
                        state             <= ACTIVE;
                        tx_shift          <= bus.tx_data_in[SIZE-2:0];
                        bit_cnt           <= '0;
                        rx_shift          <= '0;
                        bus.serial_oe_out <= 1'b1;
                        bus.busy_out      <= 1'b1;
                    end
                end
                ACTIVE: begin
                    if (cs_n_s) begin
                        state             <= END;
                        bus.serial_oe_out <= 1'b0;
                        bus.busy_out      <= 1'b0;
                    end else begin
                        if (sclk_rise) begin
                            rx_shift <= {rx_shift[SIZE-2:0], mosi_s};
                            if (bit_cnt != CNT_SAT) begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                        // The leading fall (no bit sampled yet) keeps the MSB on the line.
                        if (sclk_fall && bit_cnt != '0) begin
                            bus.serial_out <= tx_shift[SIZE-2];
                            tx_shift       <= {tx_shift[SIZE-3:0], 1'b0};
                        end
                    end
                end
                END: begin
                    state <= IDLE;
                    if (bit_cnt == CNT_FULL) begin
                        bus.rx_data_out  <= rx_shift;
                        bus.rx_valid_out <= 1'b1;
                    end else begin
                        bus.frame_error_out <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_responder.sv
// Randomized bench for spi_responder: a mode-3 master drives frames and a
// frame-level model predicts MISO bits, received words and error pulses.
module tb_spi_responder;
  localparam int SIZE = 40;
  localparam int SYNC = 2;
  localparam int HALF = 4;

  logic clk_in = 1'b0;
  logic reset_in = 1'b1;
  always #5 clk_in = ~clk_in;

  spi_responder_if #(.SIZE(SIZE)) bus ();

  spi_responder #(.SIZE(SIZE), .SYNC_STAGES(SYNC)) dut (
    .clk_in  (clk_in),
    .reset_in(reset_in),
    .bus     (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [SIZE-1:0] rx_q[$];
  int              err_cnt = 0;
  logic            miso_cap[0:SIZE+7];
  logic            busy_mid;
  logic            oe_mid;
  logic [SIZE-1:0] model_rx;

  // Pulse monitor: every cycle a strobe is high is recorded separately.
  always @(negedge clk_in) begin
    if (bus.rx_valid_out) rx_q.push_back(bus.rx_data_out);
    if (bus.frame_error_out) err_cnt++;
  end

  function automatic logic [SIZE-1:0] rand_word();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[SIZE-1:0];
  endfunction

  // Expected MISO stream: the loaded word MSB first, zeros after SIZE bits.
  function automatic int miso_errors(input logic [SIZE-1:0] tx, input int nbits);
    int bad;
    logic exp_bit;
    bad = 0;
    for (int i = 0; i < nbits; i++) begin
      exp_bit = (i < SIZE) ? tx[SIZE-1-i] : 1'b0;
      if (miso_cap[i] !== exp_bit) bad++;
    end
    return bad;
  endfunction

  task automatic wait_clk(input int n, input bit toggle);
    repeat (n) begin
      @(posedge clk_in);
      #1;
      if (toggle) bus.tx_data_in = rand_word();
    end
  endtask

  task automatic do_frame(input logic [SIZE-1:0] tx_word, input logic [SIZE-1:0] mosi_word,
                          input int nbits, input bit toggle, input bit release_cs, input int tail);
    @(posedge clk_in);
    #1;
    bus.tx_data_in = tx_word;
    bus.cs_n_in = 1'b0;
    wait_clk(4, 1'b0);
    wait_clk(2, toggle);
    for (int i = 0; i < nbits; i++) begin
      bus.sclk_in = 1'b0;
      bus.serial_in = (i < SIZE) ? mosi_word[SIZE-1-i] : 1'($urandom_range(0, 1));
      wait_clk(HALF, toggle);
      if (i == nbits / 2) begin
        busy_mid = bus.busy_out;
        oe_mid = bus.serial_oe_out;
      end
      miso_cap[i] = bus.serial_out;
      bus.sclk_in = 1'b1;
      wait_clk(HALF, toggle);
    end
    if (release_cs) begin
      bus.cs_n_in = 1'b1;
      wait_clk(tail, 1'b0);
    end
  endtask

  task automatic test_reset();
    wait_clk(3, 1'b0);
    vectors++;
    if ({bus.serial_out, bus.serial_oe_out, bus.rx_valid_out, bus.frame_error_out, bus.busy_out} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b expected 00000", {bus.serial_out, bus.serial_oe_out,
               bus.rx_valid_out, bus.frame_error_out, bus.busy_out});
    end
    vectors++;
    if (bus.rx_data_out !== '0) begin
      miscompares++;
      $display("FAIL reset_rx_data: got %h expected 0", bus.rx_data_out);
    end
    reset_in = 1'b0;
    model_rx = '0;
    wait_clk(3, 1'b0);
  endtask

  task automatic test_basic();
    logic [SIZE-1:0] tx, mosi;
    int n0, e0, lat;
    tx = 40'h12_3456_789A;
    mosi = 40'hF0_0F_AA_55_C3;
    n0 = rx_q.size();
    e0 = err_cnt;
    do_frame(tx, mosi, SIZE, 1'b0, 1'b0, 0);
    vectors++;
    if (busy_mid !== 1'b1 || oe_mid !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_busy_oe: got busy=%b oe=%b expected 1 1", busy_mid, oe_mid);
    end
    vectors++;
    if (miso_errors(tx, SIZE) !== 0) begin
      miscompares++;
      $display("FAIL basic_miso: got %0d bad bits expected 0", miso_errors(tx, SIZE));
    end
    bus.cs_n_in = 1'b1;
    lat = -1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk_in);
      #1;
      if (bus.rx_valid_out && lat < 0) lat = k;
    end
    vectors++;
    if (lat !== SYNC + 2) begin
      miscompares++;
      $display("FAIL basic_valid_latency: got %0d expected %0d", lat, SYNC + 2);
    end
    model_rx = mosi;
    vectors++;
    if (rx_q.size() !== n0 + 1 || err_cnt !== e0) begin
      miscompares++;
      $display("FAIL basic_pulses: got valid=%0d err=%0d expected 1 0", rx_q.size() - n0, err_cnt - e0);
    end
    vectors++;
    if (bus.rx_data_out !== model_rx) begin
      miscompares++;
      $display("FAIL basic_rx_data: got %h expected %h", bus.rx_data_out, model_rx);
    end
    vectors++;
    if (bus.busy_out !== 1'b0 || bus.serial_oe_out !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_idle_after: got busy=%b oe=%b expected 0 0", bus.busy_out, bus.serial_oe_out);
    end
  endtask

  task automatic test_short();
    logic [SIZE-1:0] tx, mosi;
    int n0, e0;
    tx = rand_word();
    mosi = rand_word();
    n0 = rx_q.size();
    e0 = err_cnt;
    do_frame(tx, mosi, SIZE - 1, 1'b0, 1'b1, 10);
    vectors++;
    if (err_cnt !== e0 + 1 || rx_q.size() !== n0) begin
      miscompares++;
      $display("FAIL short_pulses: got err=%0d valid=%0d expected 1 0", err_cnt - e0, rx_q.size() - n0);
    end
    vectors++;
    if (bus.rx_data_out !== model_rx) begin
      miscompares++;
      $display("FAIL short_rx_hold: got %h expected %h", bus.rx_data_out, model_rx);
    end
    vectors++;
    if (miso_errors(tx, SIZE - 1) !== 0) begin
      miscompares++;
      $display("FAIL short_miso: got %0d bad bits expected 0", miso_errors(tx, SIZE - 1));
    end
  endtask

  task automatic test_long();
    logic [SIZE-1:0] tx, mosi;
    int n0, e0;
    tx = rand_word() | 40'h1;
    mosi = rand_word();
    n0 = rx_q.size();
    e0 = err_cnt;
    do_frame(tx, mosi, SIZE + 1, 1'b0, 1'b1, 10);
    vectors++;
    if (err_cnt !== e0 + 1 || rx_q.size() !== n0) begin
      miscompares++;
      $display("FAIL long_pulses: got err=%0d valid=%0d expected 1 0", err_cnt - e0, rx_q.size() - n0);
    end
    vectors++;
    if (miso_cap[SIZE] !== 1'b0) begin
      miscompares++;
      $display("FAIL long_extra_bit: got %b expected 0", miso_cap[SIZE]);
    end
    vectors++;
    if (miso_errors(tx, SIZE) !== 0 || bus.rx_data_out !== model_rx) begin
      miscompares++;
      $display("FAIL long_miso_rx: got %0d bad bits rx=%h expected 0 rx=%h",
               miso_errors(tx, SIZE), bus.rx_data_out, model_rx);
    end
  endtask

  task automatic test_back_to_back();
    logic [SIZE-1:0] t1, t2, m1, m2;
    int n0, e0, bad1;
    t1 = rand_word();
    t2 = ~t1;
    m1 = 40'hAAAAAAAAAA;
    m2 = 40'h5555555555;
    n0 = rx_q.size();
    e0 = err_cnt;
    do_frame(t1, m1, SIZE, 1'b0, 1'b1, 3);
    bad1 = miso_errors(t1, SIZE);
    do_frame(t2, m2, SIZE, 1'b0, 1'b1, 10);
    vectors++;
    if (rx_q.size() !== n0 + 2 || err_cnt !== e0) begin
      miscompares++;
      $display("FAIL b2b_pulses: got valid=%0d err=%0d expected 2 0", rx_q.size() - n0, err_cnt - e0);
    end else begin
      vectors++;
      if (rx_q[n0] !== m1 || rx_q[n0+1] !== m2) begin
        miscompares++;
        $display("FAIL b2b_words: got %h %h expected %h %h", rx_q[n0], rx_q[n0+1], m1, m2);
      end
    end
    vectors++;
    if (bad1 !== 0 || miso_errors(t2, SIZE) !== 0) begin
      miscompares++;
      $display("FAIL b2b_miso: got %0d/%0d bad bits expected 0/0", bad1, miso_errors(t2, SIZE));
    end
    model_rx = m2;
  endtask

  task automatic test_reset_mid();
    logic [SIZE-1:0] tx, mosi;
    int n0, e0;
    tx = rand_word() | {1'b1, {(SIZE-1){1'b0}}};
    mosi = rand_word();
    n0 = rx_q.size();
    e0 = err_cnt;
    do_frame(tx, mosi, 20, 1'b0, 1'b0, 0);
    #2;
    reset_in = 1'b1;
    #1;
    vectors++;
    if ({bus.serial_out, bus.serial_oe_out, bus.rx_valid_out, bus.frame_error_out, bus.busy_out} !== 5'b0
        || bus.rx_data_out !== '0) begin
      miscompares++;
      $display("FAIL midreset_async: got ctrl=%b rx=%h expected 00000 0", {bus.serial_out,
               bus.serial_oe_out, bus.rx_valid_out, bus.frame_error_out, bus.busy_out}, bus.rx_data_out);
    end
    model_rx = '0;
    bus.cs_n_in = 1'b1;
    bus.sclk_in = 1'b1;
    wait_clk(3, 1'b0);
    reset_in = 1'b0;
    wait_clk(12, 1'b0);
    vectors++;
    if (rx_q.size() !== n0 || err_cnt !== e0) begin
      miscompares++;
      $display("FAIL midreset_no_pulse: got valid=%0d err=%0d expected 0 0", rx_q.size() - n0, err_cnt - e0);
    end
    tx = rand_word();
    mosi = rand_word();
    do_frame(tx, mosi, SIZE, 1'b0, 1'b1, 10);
    model_rx = mosi;
    vectors++;
    if (rx_q.size() !== n0 + 1 || bus.rx_data_out !== model_rx || miso_errors(tx, SIZE) !== 0) begin
      miscompares++;
      $display("FAIL midreset_next_frame: got valid=%0d rx=%h bad=%0d expected 1 %h 0",
               rx_q.size() - n0, bus.rx_data_out, miso_errors(tx, SIZE), model_rx);
    end
  endtask

  task automatic test_tx_toggle();
    logic [SIZE-1:0] tx, mosi;
    tx = rand_word();
    mosi = rand_word();
    do_frame(tx, mosi, SIZE, 1'b1, 1'b1, 10);
    model_rx = mosi;
    vectors++;
    if (miso_errors(tx, SIZE) !== 0) begin
      miscompares++;
      $display("FAIL toggle_miso: got %0d bad bits expected 0", miso_errors(tx, SIZE));
    end
    vectors++;
    if (bus.rx_data_out !== model_rx) begin
      miscompares++;
      $display("FAIL toggle_rx: got %h expected %h", bus.rx_data_out, model_rx);
    end
  endtask

  task automatic test_idle_sclk();
    logic [SIZE-1:0] tx;
    int n0, e0, bad;
    tx = rand_word();
    bus.tx_data_in = tx;
    bus.cs_n_in = 1'b1;
    n0 = rx_q.size();
    e0 = err_cnt;
    bad = 0;
    for (int h = 0; h < 20; h++) begin
      bus.sclk_in = ~bus.sclk_in;
      bus.serial_in = 1'($urandom_range(0, 1));
      repeat (HALF) begin
        @(posedge clk_in);
        #1;
        if (bus.busy_out !== 1'b0 || bus.serial_oe_out !== 1'b0) bad++;
      end
    end
    wait_clk(4, 1'b0);
    vectors++;
    if (bad !== 0 || rx_q.size() !== n0 || err_cnt !== e0) begin
      miscompares++;
      $display("FAIL idle_sclk: got active=%0d valid=%0d err=%0d expected 0 0 0", bad, rx_q.size() - n0, err_cnt - e0);
    end
    vectors++;
    if (bus.serial_out !== tx[SIZE-1] || bus.rx_data_out !== model_rx) begin
      miscompares++;
      $display("FAIL idle_outputs: got so=%b rx=%h expected %b %h", bus.serial_out, bus.rx_data_out, tx[SIZE-1], model_rx);
    end
  endtask

  task automatic test_random();
    logic [SIZE-1:0] tx, mosi;
    int n0, e0, nb, exp_v, exp_e;
    for (int f = 0; f < 8; f++) begin
      tx = rand_word();
      mosi = rand_word();
      case ($urandom_range(0, 3))
        0: nb = SIZE - 1;
        1: nb = SIZE + 1;
        default: nb = SIZE;
      endcase
      n0 = rx_q.size();
      e0 = err_cnt;
      do_frame(tx, mosi, nb, 1'($urandom_range(0, 1)), 1'b1, 10);
      exp_v = (nb == SIZE) ? 1 : 0;
      exp_e = 1 - exp_v;
      if (nb == SIZE) model_rx = mosi;
      vectors++;
      if (rx_q.size() - n0 !== exp_v || err_cnt - e0 !== exp_e || bus.rx_data_out !== model_rx
          || miso_errors(tx, nb) !== 0) begin
        miscompares++;
        $display("FAIL random_frame%0d: got valid=%0d err=%0d rx=%h bad=%0d expected %0d %0d %h 0",
                 f, rx_q.size() - n0, err_cnt - e0, bus.rx_data_out, miso_errors(tx, nb), exp_v, exp_e, model_rx);
      end
    end
  endtask

  initial begin
    bus.sclk_in = 1'b1;
    bus.cs_n_in = 1'b1;
    bus.serial_in = 1'b0;
    bus.tx_data_in = '0;
    busy_mid = 1'b0;
    oe_mid = 1'b0;
    model_rx = '0;
    test_reset();
    test_basic();
    test_short();
    test_long();
    test_back_to_back();
    test_reset_mid();
    test_tx_toggle();
    test_idle_sclk();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/spi_responder.md
Name: spi_responder

Overview:
SPI mode 3 (CPOL=1, CPHA=1) peripheral-side unit. It is the counterpart of the team's SPI master, and all transfers are MSB first.
The block is oversampled: sclk_in, cs_n_in and serial_in are synchronized into the clk_in domain, and all shifting happens on detected sclk edges.
A parallel word is loaded for transmission when chip select asserts. The received word is presented with a one-cycle valid strobe when chip select releases after exactly SIZE bits.
Used for loopback verification of the master and for FPGA-to-FPGA links.

Parameters:
SIZE, 40, bits per frame (datagram width)
SYNC_STAGES, 2, flip-flop stages on sclk_in/cs_n_in/serial_in synchronizers (>=2)

Ports:
clk_in  input  1  system clock; all logic on posedge
reset_in  input  1  asynchronous, active-high reset
sclk_in  input  1  SPI clock from master; idles high
cs_n_in  input  1  chip select from master, active low
serial_in  input  1  MOSI
serial_out  output  1  MISO data
serial_oe_out  output  1  MISO output enable; high only while a frame is active
tx_data_in  input  SIZE  word to send; sampled on the IDLE->ACTIVE transition
rx_data_out  output  SIZE  last correctly received word; holds until the next good frame
rx_valid_out  output  1  one-cycle pulse when rx_data_out is updated
frame_error_out  output  1  one-cycle pulse when a frame ends with bit count != SIZE
busy_out  output  1  high while in ACTIVE

Behaviour:
Reset (asynchronous, active-high):
- Outputs: serial_out=0, serial_oe_out=0, rx_data_out=0, rx_valid_out=0, frame_error_out=0, busy_out=0.
- State=IDLE; synchronizer flops preset to sclk=1, cs_n=1, mosi=0.

Synchronization and edge detection:
- sclk_in, cs_n_in and serial_in pass through identical SYNC_STAGES chains, so sampled data stays aligned with the detected edge.
- Rise = synced sclk 1 and previous synced sclk 0; fall = the reverse.
- Constraint: sclk high and low times >= 3 clk_in cycles. Behaviour is undefined otherwise.

FSM states: IDLE, ACTIVE, END.
- IDLE:
  - synced cs_n==0 -> ACTIVE; load tx shift reg from tx_data_in; bit counter=0; clear rx shift reg.
  - serial_out driven with tx_data_in[SIZE-1] from the same cycle.
  - sclk edges are ignored.
- ACTIVE:
  - busy_out=1, serial_oe_out=1.
  - Rise: rx shift reg <= {rx[SIZE-2:0], synced mosi}; counter increments, saturating at SIZE+1.
  - Fall with counter>0: tx shift reg shifts left by one, serial_out <= next bit.
  - Fall with counter==0 (the leading edge): no shift; the MSB stays on the line.
  - Bits past SIZE shift 0 out on serial_out.
  - Synced cs_n==1 -> END. This takes priority over an sclk edge detected in the same cycle, which is discarded.
- END (exactly one cycle):
  - serial_oe_out=0, busy_out=0.
  - counter==SIZE: rx_data_out <= rx shift reg, rx_valid_out=1 for this cycle.
  - Otherwise: frame_error_out=1 for this cycle; rx_data_out unchanged.
  - Next state is IDLE, which can restart on the following cycle if cs_n is already low again.

Other rules:
- Latency: cs_n_in edge to state change = SYNC_STAGES+1 clk_in cycles. The rx_valid_out pulse occurs SYNC_STAGES+2 cycles after cs_n_in rises.
- tx_data_in changes during ACTIVE have no effect.
- Reset mid-frame: reset aborts the frame with no valid or error pulse. If cs_n is still low when reset releases, a new frame starts mid-transfer and will end with frame_error_out unless the remaining bit count is exactly SIZE.
- serial_out holds its last value when serial_oe_out=0. It is not tri-stated internally; the top level uses serial_oe_out.

Test Plan:
- SIZE=40, tx_data_in=40'h12_3456_789A; master (mode 3, clk divider 4) sends 40'hF0_0F_AA_55_C3 -> MISO bitstream equals 40'h12_3456_789A MSB first; rx_data_out=40'hF0_0F_AA_55_C3; exactly one rx_valid_out pulse; frame_error_out never asserted.
- Short frame: cs_n released after 39 clocks -> frame_error_out pulses once; rx_valid_out stays 0; rx_data_out keeps the previous value.
- Long frame: 41 sclk cycles -> frame_error_out pulse; 41st MISO bit is 0.
- Back-to-back frames with cs_n high for 4 clk_in cycles; words 40'hAAAAAAAAAA then 40'h5555555555 -> two rx_valid_out pulses with correct data; second tx word is taken from tx_data_in at the second assert.
- reset_in pulsed at bit 20 -> all outputs return to reset values immediately (asynchronous reset); no valid or error pulse for the aborted frame; the next full frame is received correctly.
- tx_data_in toggled every cycle during ACTIVE -> MISO stream still equals the word sampled at cs_n assertion; sclk toggling while cs_n high -> no output activity, busy_out=0.
